// File: rtl/output_sram_arbiter_pkg.sv
// Shared types and constants for the output-SRAM write-port arbiter.
package output_sram_arbiter_pkg;

    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned FV_W       = 16;
    localparam int unsigned NODE_ID_W  = 10;
    localparam int unsigned BEAT_IDX_W = 3;
    localparam int unsigned MAX_BEATS  = 8;
    localparam int unsigned BEAT_W     = 2 * FV_W;
    localparam int unsigned ADDR_W     = NODE_ID_W + BEAT_IDX_W;
    localparam int unsigned IDX_W      = $clog2(NUM_BANKS);
    localparam int unsigned CNT_W      = BEAT_IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_STREAM = 2'd2
    } arb_state_e;

    // One bank's beat as seen by the arbiter
    typedef struct packed {
        logic                 valid;
        logic                 sos;
        logic                 eos;
        logic [NODE_ID_W-1:0] node_id;
        logic [BEAT_W-1:0]    data;
    } Bank_Req2Req_Output_SRAM;

    // Bank index 'off' positions after 'last', wrapping
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] last,
                                                input int unsigned      off);
        return IDX_W'((32'(last) + off) % NUM_BANKS);
    endfunction

endpackage

// File: rtl/output_sram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending bank after the last winner.
module output_sram_arbiter_rr_arbiter
    import output_sram_arbiter_pkg::*;
(
    input  logic [NUM_BANKS-1:0] i_pending,
    input  logic [IDX_W-1:0]     i_last,
    output logic [NUM_BANKS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_valid
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned off = 1; off <= NUM_BANKS; off++) begin
            if (!o_valid && i_pending[rr_idx(i_last, off)]) begin
                o_valid                      = 1'b1;
                o_idx                        = rr_idx(i_last, off);
                o_grant[rr_idx(i_last, off)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_sram_arbiter.sv
// Arbitrates the single output-SRAM write port among the vertex accumulation buffers
// and forwards the granted bank's burst as registered SRAM writes.
module output_sram_arbiter
    import output_sram_arbiter_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BANKS-1:0]          bank_req,
    input  logic [NUM_BANKS-1:0]          bank_valid,
    input  logic [NUM_BANKS-1:0]          bank_sos,
    input  logic [NUM_BANKS-1:0]          bank_eos,
    input  logic [NUM_BANKS*NODE_ID_W-1:0] bank_node_id,
    input  logic [NUM_BANKS*BEAT_W-1:0]   bank_data,
    output logic [NUM_BANKS-1:0]          req_grant,
    output logic                          sram_wr_en,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [BEAT_W-1:0]             sram_wdata,
    output logic                          busy,
    output logic                          proto_err
);

    arb_state_e              r_state;
    logic [NUM_BANKS-1:0]    r_pending;
    logic [IDX_W-1:0]        r_sel;
    logic [NUM_BANKS-1:0]    r_sel_oh;
    logic [IDX_W-1:0]        r_last;
    logic [CNT_W-1:0]        r_cnt;
    logic [NODE_ID_W-1:0]    r_node;
    logic                    r_wr_en;
    logic [ADDR_W-1:0]       r_addr;
    logic [BEAT_W-1:0]       r_wdata;
    logic                    r_busy;
    logic                    r_proto_err;

    Bank_Req2Req_Output_SRAM w_bank [NUM_BANKS];
    Bank_Req2Req_Output_SRAM w_beat;
    logic [NUM_BANKS-1:0]    w_arb_grant;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_arb_valid;
    logic [NUM_BANKS-1:0]    w_clr;
    logic [NUM_BANKS-1:0]    w_pending_nxt;
    logic [NUM_BANKS-1:0]    w_sel_mask;
    logic                    w_stray;
    logic                    w_hit_max;
    logic [NODE_ID_W-1:0]    w_wr_node;
    logic                    w_accept;
    logic                    w_end;
    logic                    w_err_fsm;
    logic                    w_busy_nxt;

    output_sram_arbiter_rr_arbiter u_rr (
        .i_pending (r_pending),
        .i_last    (r_last),
        .o_grant   (w_arb_grant),
        .o_idx     (w_arb_idx),
        .o_valid   (w_arb_valid)
    );

    // Unpack the flat bank buses
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_bank[i].valid   = bank_valid[i];
            w_bank[i].sos     = bank_sos[i];
            w_bank[i].eos     = bank_eos[i];
            w_bank[i].node_id = bank_node_id[i*NODE_ID_W +: NODE_ID_W];
            w_bank[i].data    = bank_data[i*BEAT_W +: BEAT_W];
        end
    end

    assign w_beat        = w_bank[r_sel];
    assign req_grant     = (r_state == S_GRANT) ? r_sel_oh : '0;
    assign w_clr         = req_grant;
    assign w_pending_nxt = (r_pending & ~w_clr) | bank_req;
    assign w_sel_mask    = (r_state == S_IDLE) ? '0 : r_sel_oh;
    assign w_stray       = |(bank_valid & ~w_sel_mask);
    assign w_hit_max     = (r_cnt + CNT_W'(1)) == CNT_W'(MAX_BEATS);
    assign w_wr_node     = (r_state == S_GRANT) ? w_beat.node_id : r_node;

    // Beat acceptance, burst termination and in-burst protocol faults
    always_comb begin
        w_accept  = 1'b0;
        w_end     = 1'b0;
        w_err_fsm = 1'b0;
        case (r_state)
            S_GRANT: begin
                w_accept  = w_beat.valid & w_beat.sos;
                w_end     = !w_accept | w_beat.eos | w_hit_max;
                w_err_fsm = !w_accept | (!w_beat.eos & w_hit_max);
            end
            S_STREAM: begin
                w_accept  = w_beat.valid;
                w_end     = w_beat.valid & (w_beat.eos | w_hit_max);
                w_err_fsm = w_beat.valid & (w_beat.sos | (!w_beat.eos & w_hit_max));
            end
            default: ;
        endcase
    end

    assign w_busy_nxt = (|w_pending_nxt) |
                        ((r_state == S_IDLE) ? w_arb_valid : !w_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_sel       <= '0;
            r_sel_oh    <= '0;
            r_last      <= IDX_W'(NUM_BANKS - 1);
            r_cnt       <= '0;
            r_node      <= '0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_en   <= w_accept;
            if (w_accept) begin
                r_addr  <= {w_wr_node, r_cnt[BEAT_IDX_W-1:0]};
                r_wdata <= w_beat.data;
            end
            if (w_stray || w_err_fsm) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_arb_valid) begin
                        r_sel    <= w_arb_idx;
                        r_sel_oh <= w_arb_grant;
                        r_last   <= w_arb_idx;
                        r_cnt    <= '0;
                        r_state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_accept) begin
                        r_node <= w_beat.node_id;
                        r_cnt  <= CNT_W'(1);
                    end
                    r_state <= w_end ? S_IDLE : S_STREAM;
                end
                S_STREAM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_end) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sram_wr_en = r_wr_en;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign busy       = r_busy;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_output_sram_arbiter.sv
// Directed self-checking bench for output_sram_arbiter.
module tb_output_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  bank_req, bank_valid, bank_sos, bank_eos;
    logic [39:0] bank_node_id;
    logic [127:0] bank_data;
    logic [3:0]  req_grant;
    logic        sram_wr_en;
    logic [12:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        busy, proto_err;

    int errors = 0;
    int checks = 0;

    output_sram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .bank_req     (bank_req),
        .bank_valid   (bank_valid),
        .bank_sos     (bank_sos),
        .bank_eos     (bank_eos),
        .bank_node_id (bank_node_id),
        .bank_data    (bank_data),
        .req_grant    (req_grant),
        .sram_wr_en   (sram_wr_en),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] beat_data(input int b, input int k, input logic [9:0] nid);
        return {6'd0, nid, 8'(b), 8'(k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        bank_valid   = '0;
        bank_sos     = '0;
        bank_eos     = '0;
        bank_node_id = '0;
        bank_data    = '0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bank_req = '0;
        clear_beats();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits for bank b's grant, streams nbeats and checks each write one cycle later
    task automatic run_burst(input int b, input logic [9:0] nid, input int nbeats,
                             input bit eos_last, input logic [3:0] req_in_grant,
                             input int intrude_beat, output int waited);
        waited = 0;
        do begin
            tick();
            bank_req = '0;
            waited++;
            if (req_grant == 4'd0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_wait bank%0d: got %b want 1", b, busy);
                end
            end
        end while (req_grant == 4'd0 && waited < 8);
        checks++;
        if (req_grant !== 4'(1 << b)) begin
            errors++;
            $display("FAIL grant bank%0d: got %b want %b", b, req_grant, 4'(1 << b));
            clear_beats();
            return;
        end
        bank_req = req_in_grant;
        for (int k = 0; k < nbeats; k++) begin
            clear_beats();
            bank_valid[b]              = 1'b1;
            bank_sos[b]                = (k == 0);
            bank_eos[b]                = eos_last && (k == nbeats - 1);
            bank_node_id[b*10 +: 10]   = nid;
            bank_data[b*32 +: 32]      = beat_data(b, k, nid);
            if (k == intrude_beat) begin
                bank_valid[(b+1)%4]        = 1'b1;
                bank_data[((b+1)%4)*32 +: 32] = 32'hDEAD_BEEF;
            end
            tick();
            bank_req = '0;
            if (k == 0) begin
                checks++;
                if (req_grant !== 4'd0) begin
                    errors++;
                    $display("FAIL grant_pulse bank%0d: got %b want 0000", b, req_grant);
                end
            end
            if (k < 8) begin
                checks += 3;
                if (sram_wr_en !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_en bank%0d beat%0d: got %b want 1", b, k, sram_wr_en);
                end
                if (sram_addr !== {nid, 3'(k)}) begin
                    errors++;
                    $display("FAIL addr bank%0d beat%0d: got %h want %h", b, k, sram_addr, {nid, 3'(k)});
                end
                if (sram_wdata !== beat_data(b, k, nid)) begin
                    errors++;
                    $display("FAIL wdata bank%0d beat%0d: got %h want %h", b, k, sram_wdata, beat_data(b, k, nid));
                end
            end else begin
                checks++;
                if (sram_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL dropped_beat bank%0d beat%0d: wr_en got %b want 0", b, k, sram_wr_en);
                end
            end
        end
        clear_beats();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (req_grant !== 4'd0)  begin errors++; $display("FAIL reset_grant: got %b want 0", req_grant); end
        if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", sram_wr_en); end
        if (sram_addr !== 13'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
        if (sram_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", sram_wdata); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (proto_err !== 1'b0)  begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    endtask

    task automatic test_single();
        int w;
        bank_req = 4'b0001;
        run_burst(0, 10'd5, 2, 1'b1, 4'b0000, -1, w);
        checks += 3;
        if (w !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", w); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", busy); end
        tick();
        if (sram_wr_en !== 1'b0) begin errors++; $display("FAIL single_idle_wr: got %b want 0", sram_wr_en); end
    endtask

    task automatic test_all_four();
        int w;
        do_reset();
        bank_req = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            run_burst(b, 10'(100 + b), 2 + b, 1'b1, 4'b0000, -1, w);
            checks++;
            if (w !== ((b == 0) ? 2 : 1)) begin
                errors++;
                $display("FAIL all4_gap bank%0d: got %0d want %0d", b, w, (b == 0) ? 2 : 1);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL all4_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int w;
        int order [3] = '{3, 0, 2};
        bank_req = 4'b0100;
        run_burst(2, 10'd200, 2, 1'b1, 4'b1101, -1, w);
        for (int i = 0; i < 3; i++) begin
            run_burst(order[i], 10'(300 + i), 1, 1'b1, 4'b0000, -1, w);
            checks++;
            if (w !== 1) begin errors++; $display("FAIL rr_gap step%0d: got %0d want 1", i, w); end
        end
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL rr_proto_err: got %b want 0", proto_err); end
    endtask

    task automatic test_intrude();
        int w;
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL intrude_pre_err: got %b want 0", proto_err); end
        bank_req = 4'b0001;
        run_burst(0, 10'd9, 3, 1'b1, 4'b0000, 1, w);
        checks += 2;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL intrude_proto_err: got %b want 1", proto_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL intrude_busy: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        int w;
        do_reset();
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL timeout_pre_err: got %b want 0", proto_err); end
        bank_req = 4'b1000;
        run_burst(3, 10'd7, 9, 1'b0, 4'b0000, -1, w);
        checks += 2;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL timeout_proto_err: got %b want 1", proto_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        int w;
        do_reset();
        bank_req = 4'b0001;
        tick();
        bank_req = '0;
        tick();
        checks++;
        if (req_grant !== 4'b0001) begin errors++; $display("FAIL rmid_grant: got %b want 0001", req_grant); end
        for (int k = 0; k < 4; k++) begin
            clear_beats();
            bank_valid[0]        = 1'b1;
            bank_sos[0]          = (k == 0);
            bank_node_id[9:0]    = 10'd44;
            bank_data[31:0]      = beat_data(0, k, 10'd44);
            bank_req             = (k == 0) ? 4'b1000 : 4'b0000;
            if (k == 3) reset = 1'b1;
            tick();
        end
        bank_req = '0;
        clear_beats();
        checks += 6;
        if (req_grant !== 4'd0)   begin errors++; $display("FAIL rmid_grant0: got %b want 0", req_grant); end
        if (sram_wr_en !== 1'b0)  begin errors++; $display("FAIL rmid_wr_en: got %b want 0", sram_wr_en); end
        if (sram_addr !== 13'd0)  begin errors++; $display("FAIL rmid_addr: got %h want 0", sram_addr); end
        if (sram_wdata !== 32'd0) begin errors++; $display("FAIL rmid_wdata: got %h want 0", sram_wdata); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        if (proto_err !== 1'b0)   begin errors++; $display("FAIL rmid_proto_err: got %b want 0", proto_err); end
        reset = 1'b0;
        tick();
        checks += 2;
        if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_pending_lost: busy got %b want 0", busy); end
        if (req_grant !== 4'd0) begin errors++; $display("FAIL rmid_no_grant: got %b want 0", req_grant); end
        bank_req = 4'b0010;
        run_burst(1, 10'd55, 2, 1'b1, 4'b0000, -1, w);
        checks += 2;
        if (w !== 2) begin errors++; $display("FAIL rmid_new_latency: got %0d want 2", w); end
        if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_new_err: got %b want 0", proto_err); end
    endtask

    initial begin
        reset    = 1'b1;
        bank_req = '0;
        clear_beats();
        test_reset();
        test_single();
        test_all_four();
        test_round_robin();
        test_intrude();
        test_timeout();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
